// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing generator. It produces the pixel
//            enable, h/v sync, blanking, pixel coordinates and line/frame
//            strobes. Defining VGA_TIMING_FRAME_CNT_EN adds the frame_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 2,
  parameter bit HS_ACT  = 1'b0,
  parameter bit VS_ACT  = 1'b0,
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int c_H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   c_H_LAST    = CNT_W'(c_H_TOTAL - 1);
  localparam logic [CNT_W-1:0]   c_V_LAST    = CNT_W'(c_V_TOTAL - 1);
  localparam logic [CNT_W-1:0]   c_H_DISP    = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0]   c_V_DISP    = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0]   c_HS_START  = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0]   c_HS_END    = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0]   c_VS_START  = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0]   c_VS_END    = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

  localparam bit c_MODE_OK = (c_H_TOTAL <= (1 << CNT_W)) && (c_V_TOTAL <= (1 << CNT_W)) &&
                             (H_SYNC > 0) && (V_SYNC > 0) && (CLK_DIV >= 1) && (FRAME_W >= 1);

  generate
    if (!c_MODE_OK) begin : g_bad_mode
      $error("vga_timing_gen: illegal mode (CNT_W too narrow, zero sync width or bad divider)");
    end
  endgenerate

  logic [c_DIV_W-1:0] r_div;
  logic [CNT_W-1:0]   r_x;
  logic [CNT_W-1:0]   r_y;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_video_on;
  logic               r_x_zero;
  logic               r_y_zero;

  logic               w_tick;
  logic               w_x_wrap;
  logic               w_y_wrap;
  logic [CNT_W-1:0]   w_x_nxt;
  logic [CNT_W-1:0]   w_y_nxt;
  logic               w_hs_nxt;
  logic               w_vs_nxt;
  logic               w_vo_nxt;

  assign w_tick   = en && (r_div == c_DIV_LAST);
  assign w_x_wrap = (r_x == c_H_LAST);
  assign w_y_wrap = (r_y == c_V_LAST);
  assign w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
  assign w_y_nxt  = !w_x_wrap ? r_y : (w_y_wrap ? '0 : r_y + 1'b1);

  // Sync/blank flags are decoded from the next position so they land with x/y.
  assign w_hs_nxt = (w_x_nxt >= c_HS_START) && (w_x_nxt <= c_HS_END);
  assign w_vs_nxt = (w_y_nxt >= c_VS_START) && (w_y_nxt <= c_VS_END);
  assign w_vo_nxt = (w_x_nxt < c_H_DISP) && (w_y_nxt < c_V_DISP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= ~HS_ACT;
      r_vsync    <= ~VS_ACT;
      r_video_on <= 1'b1;
      r_x_zero   <= 1'b1;
      r_y_zero   <= 1'b1;
    end else if (en) begin
      r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_x        <= w_x_nxt;
        r_y        <= w_y_nxt;
        r_hsync    <= w_hs_nxt ? HS_ACT : ~HS_ACT;
        r_vsync    <= w_vs_nxt ? VS_ACT : ~VS_ACT;
        r_video_on <= w_vo_nxt;
        r_x_zero   <= (w_x_nxt == '0);
        r_y_zero   <= (w_y_nxt == '0);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_tick && w_x_wrap && w_y_wrap) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign p_tick      = w_tick;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign line_start  = w_tick && r_x_zero;
  assign frame_start = w_tick && r_x_zero && r_y_zero;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;

endmodule
`default_nettype wire
